// File: rtl/fall_ctrl.sv
// Active-brick sequencer: spawn, gravity fall, lock delay, commit handshake, respawn.
// Drives pos/brick_type/dir into the drop/collision datapath and reacts to its
// landing position and legality flags. All outputs come straight from flops.
module fall_ctrl #(
  parameter int unsigned GRAVITY_CYCLES = 25000000,
  parameter int unsigned SOFT_CYCLES    = 2500000,
  parameter int unsigned LOCK_CYCLES    = 12500000,
  parameter int unsigned SPAWN_POS      = (19 << 5) | 4,
  parameter int unsigned CNT_W          = 25,
  parameter int unsigned POS_LEN        = 10,
  parameter int unsigned BRICK_LEN      = 3,
  parameter int unsigned DIR_LEN        = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BRICK_LEN-1:0] next_type,
  output logic                 next_req,
  input  logic                 spawn_ok,
  input  logic [POS_LEN-1:0]   land_pos,
  input  logic                 soft_drop,
  input  logic                 hard_drop,
  input  logic                 rot_req,
  input  logic                 rot_ok,
  input  logic                 commit_ack,
  output logic [POS_LEN-1:0]   pos,
  output logic [BRICK_LEN-1:0] brick_type,
  output logic [DIR_LEN-1:0]   dir,
  output logic                 active,
  output logic                 commit_req,
  output logic                 game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_CHECK,
    S_FALL,
    S_LOCK,
    S_COMMIT,
    S_OVER
  } state_t;

  localparam logic [CNT_W-1:0]   GRAV_LAST = CNT_W'(GRAVITY_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [POS_LEN-1:0] SPAWN_P   = POS_LEN'(SPAWN_POS);
  localparam logic [POS_LEN-1:0] ROW_STEP  = POS_LEN'(32);

  state_t               state_q;
  logic [CNT_W-1:0]     timer_q;
  logic [POS_LEN-1:0]   pos_q;
  logic [BRICK_LEN-1:0] type_q;
  logic [DIR_LEN-1:0]   dir_q;
  logic                 next_req_q;
  logic                 active_q;
  logic                 commit_req_q;
  logic                 game_over_q;

  logic step_due;
  logic rot_go;
  logic grounded;

  // Gravity step and rotation qualifiers; a mid-count soft_drop raise steps at once.
  always_comb begin
    step_due = soft_drop ? (timer_q >= SOFT_LAST) : (timer_q >= GRAV_LAST);
    rot_go   = rot_req && rot_ok;
    grounded = (land_pos == pos_q);
  end

  // Brick life-cycle FSM; output flags are loaded on the edge entering each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      pos_q        <= SPAWN_P;
      type_q       <= '0;
      dir_q        <= '0;
      next_req_q   <= 1'b0;
      active_q     <= 1'b0;
      commit_req_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      next_req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_SPAWN;
            next_req_q <= 1'b1;
          end
        end
        S_SPAWN: begin
          pos_q   <= SPAWN_P;
          type_q  <= next_type;
          dir_q   <= '0;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          timer_q <= '0;
          if (spawn_ok) begin
            state_q  <= S_FALL;
            active_q <= 1'b1;
          end else begin
            state_q     <= S_OVER;
            game_over_q <= 1'b1;
          end
        end
        S_FALL: begin
          if (hard_drop) begin
            pos_q        <= land_pos;
            state_q      <= S_COMMIT;
            active_q     <= 1'b0;
            commit_req_q <= 1'b1;
          end else if (step_due) begin
            timer_q <= '0;
            if (grounded) begin
              state_q <= S_LOCK;
            end else begin
              pos_q <= pos_q - ROW_STEP;
            end
          end else begin
            timer_q <= timer_q + CNT_W'(1);
            if (rot_go) begin
              dir_q <= dir_q + DIR_LEN'(1);
            end
          end
        end
        S_LOCK: begin
          // Losing ground wins over expiry; rotation is still allowed on that cycle.
          if (hard_drop) begin
            pos_q        <= land_pos;
            state_q      <= S_COMMIT;
            active_q     <= 1'b0;
            commit_req_q <= 1'b1;
          end else if (!grounded) begin
            state_q <= S_FALL;
            timer_q <= '0;
            if (rot_go) begin
              dir_q <= dir_q + DIR_LEN'(1);
            end
          end else if (timer_q >= LOCK_LAST) begin
            state_q      <= S_COMMIT;
            active_q     <= 1'b0;
            commit_req_q <= 1'b1;
          end else begin
            timer_q <= timer_q + CNT_W'(1);
            if (rot_go) begin
              dir_q <= dir_q + DIR_LEN'(1);
            end
          end
        end
        S_COMMIT: begin
          if (commit_ack) begin
            commit_req_q <= 1'b0;
            state_q      <= S_SPAWN;
            next_req_q   <= 1'b1;
          end
        end
        S_OVER: begin
          if (start) begin
            game_over_q <= 1'b0;
            state_q     <= S_SPAWN;
            next_req_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pos        = pos_q;
  assign brick_type = type_q;
  assign dir        = dir_q;
  assign next_req   = next_req_q;
  assign active     = active_q;
  assign commit_req = commit_req_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_fall_ctrl.sv
// Directed bench for fall_ctrl with short timing parameters.
module tb_fall_ctrl;

  localparam int unsigned POS_LEN   = 10;
  localparam int unsigned BRICK_LEN = 3;
  localparam int unsigned DIR_LEN   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [BRICK_LEN-1:0] next_type;
  logic                 next_req;
  logic                 spawn_ok;
  logic [POS_LEN-1:0]   land_pos;
  logic                 soft_drop;
  logic                 hard_drop;
  logic                 rot_req;
  logic                 rot_ok;
  logic                 commit_ack;
  logic [POS_LEN-1:0]   pos;
  logic [BRICK_LEN-1:0] brick_type;
  logic [DIR_LEN-1:0]   dir;
  logic                 active;
  logic                 commit_req;
  logic                 game_over;

  int passed = 0;
  int total  = 0;

  fall_ctrl #(
    .GRAVITY_CYCLES(4),
    .SOFT_CYCLES   (2),
    .LOCK_CYCLES   (3),
    .SPAWN_POS     ((19 << 5) | 4),
    .CNT_W         (8),
    .POS_LEN       (POS_LEN),
    .BRICK_LEN     (BRICK_LEN),
    .DIR_LEN       (DIR_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .next_type (next_type),
    .next_req  (next_req),
    .spawn_ok  (spawn_ok),
    .land_pos  (land_pos),
    .soft_drop (soft_drop),
    .hard_drop (hard_drop),
    .rot_req   (rot_req),
    .rot_ok    (rot_ok),
    .commit_ack(commit_ack),
    .pos       (pos),
    .brick_type(brick_type),
    .dir       (dir),
    .active    (active),
    .commit_req(commit_req),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    next_type  = '0;
    spawn_ok   = 1'b0;
    land_pos   = 10'h084;
    soft_drop  = 1'b0;
    hard_drop  = 1'b0;
    rot_req    = 1'b0;
    rot_ok     = 1'b0;
    commit_ack = 1'b0;
    tick();
    tick();
    chk("rst_pos", 32'(pos), 32'h264);
    chk("rst_type", 32'(brick_type), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_flags", {28'd0, next_req, active, commit_req, game_over}, 0);
    rst_n = 1'b1;
    tick();

    // first spawn, type 3
    start = 1'b1; next_type = 3'd3; spawn_ok = 1'b1;
    tick();
    start = 1'b0;
    chk("spawn_next_req", 32'(next_req), 1);
    chk("spawn_active0", 32'(active), 0);
    tick();
    chk("check_next_req0", 32'(next_req), 0);
    chk("check_type", 32'(brick_type), 3);
    tick();
    chk("fall_active", 32'(active), 1);
    chk("fall_pos", 32'(pos), 32'h264);

    // one gravity step then async reset mid-count
    repeat (3) tick();
    chk("grav_hold", 32'(pos), 32'h264);
    tick();
    chk("grav_step1", 32'(pos), 32'h244);
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_pos", 32'(pos), 32'h264);
    chk("async_rst_type", 32'(brick_type), 0);
    chk("async_rst_active", 32'(active), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // respawn and fall all the way to row 4
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("respawn_active", 32'(active), 1);
    for (int k = 1; k <= 15; k++) begin
      repeat (3) tick();
      chk("grav_mid", 32'(pos), 32'(10'h264 - 10'(32 * (k - 1))));
      tick();
      chk("grav_step", 32'(pos), 32'(10'h264 - 10'(32 * k)));
    end
    // grounded: enters LOCK on the next step
    repeat (4) tick();
    chk("lock_pos", 32'(pos), 32'h084);
    chk("lock_active", 32'(active), 1);
    chk("lock_req0", 32'(commit_req), 0);
    tick();
    tick();
    chk("lock_req_wait", 32'(commit_req), 0);
    tick();
    chk("lock_commit", 32'(commit_req), 1);
    chk("lock_commit_active", 32'(active), 0);
    chk("lock_commit_pos", 32'(pos), 32'h084);
    commit_ack = 1'b1; next_type = 3'd5;
    tick();
    commit_ack = 1'b0;
    chk("ack_req0", 32'(commit_req), 0);
    chk("ack_next_req", 32'(next_req), 1);
    tick();
    tick();
    chk("spawn2_type", 32'(brick_type), 5);
    chk("spawn2_pos", 32'(pos), 32'h264);

    // hard drop with a simultaneous rotate request
    land_pos = 10'h044; hard_drop = 1'b1; rot_req = 1'b1; rot_ok = 1'b1;
    tick();
    hard_drop = 1'b0; rot_req = 1'b0;
    chk("hd_pos", 32'(pos), 32'h044);
    chk("hd_req", 32'(commit_req), 1);
    chk("hd_dir", 32'(dir), 0);
    land_pos = 10'h104;
    for (int i = 0; i < 5; i++) begin
      hard_drop = 1'(i % 2); rot_req = 1'b1; soft_drop = 1'b1;
      tick();
      chk("hold_req", 32'(commit_req), 1);
      chk("hold_pos", 32'(pos), 32'h044);
      chk("hold_dir", 32'(dir), 0);
    end
    hard_drop = 1'b0; rot_req = 1'b0; soft_drop = 1'b0;
    land_pos = 10'h264;
    commit_ack = 1'b1;
    tick();
    commit_ack = 1'b0;
    chk("hd_ack_req0", 32'(commit_req), 0);
    chk("hd_ack_next_req", 32'(next_req), 1);
    tick();
    tick();

    // lock escape
    repeat (4) tick();
    chk("esc_lock_active", 32'(active), 1);
    chk("esc_lock_pos", 32'(pos), 32'h264);
    tick();
    land_pos = 10'h244;
    tick();
    chk("esc_req0", 32'(commit_req), 0);
    repeat (3) tick();
    chk("esc_hold", 32'(pos), 32'h264);
    chk("esc_req_still0", 32'(commit_req), 0);
    tick();
    chk("esc_step", 32'(pos), 32'h244);

    // soft drop
    land_pos = 10'h084; soft_drop = 1'b1;
    tick();
    chk("soft_hold", 32'(pos), 32'h244);
    tick();
    chk("soft_step1", 32'(pos), 32'h224);
    tick();
    tick();
    chk("soft_step2", 32'(pos), 32'h204);
    soft_drop = 1'b0;
    tick();
    tick();
    chk("soft_off_hold", 32'(pos), 32'h204);
    soft_drop = 1'b1;
    tick();
    chk("soft_late_raise", 32'(pos), 32'h1e4);
    soft_drop = 1'b0;

    // rotation
    rot_req = 1'b1; rot_ok = 1'b1;
    tick();
    chk("rot1", 32'(dir), 1);
    tick();
    chk("rot2", 32'(dir), 2);
    tick();
    chk("rot3", 32'(dir), 3);
    rot_req = 1'b0;
    tick();
    chk("rot_step_pos", 32'(pos), 32'h1c4);
    rot_req = 1'b1;
    tick();
    chk("rot_wrap", 32'(dir), 0);
    rot_ok = 1'b0;
    tick();
    chk("rot_illegal", 32'(dir), 0);
    rot_req = 1'b0;
    tick();
    rot_req = 1'b1; rot_ok = 1'b1;
    tick();
    chk("rot_vs_step_dir", 32'(dir), 0);
    chk("rot_vs_step_pos", 32'(pos), 32'h1a4);
    rot_req = 1'b0;

    // game over
    land_pos = 10'h1a4; hard_drop = 1'b1;
    tick();
    hard_drop = 1'b0;
    chk("go_commit", 32'(commit_req), 1);
    commit_ack = 1'b1; spawn_ok = 1'b0;
    tick();
    commit_ack = 1'b0;
    tick();
    tick();
    chk("go_flag", 32'(game_over), 1);
    chk("go_active", 32'(active), 0);
    hard_drop = 1'b1; rot_req = 1'b1; rot_ok = 1'b1; commit_ack = 1'b1;
    tick();
    hard_drop = 1'b0; rot_req = 1'b0; commit_ack = 1'b0;
    chk("go_stays", 32'(game_over), 1);
    chk("go_dir", 32'(dir), 0);
    chk("go_pos", 32'(pos), 32'h264);
    chk("go_req0", 32'(commit_req), 0);
    start = 1'b1; spawn_ok = 1'b1; next_type = 3'd6;
    tick();
    start = 1'b0;
    chk("restart_go0", 32'(game_over), 0);
    chk("restart_next_req", 32'(next_req), 1);
    tick();
    tick();
    chk("restart_active", 32'(active), 1);
    chk("restart_type", 32'(brick_type), 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
